ppu_vram_arbiter: RTL and testbench

Shares the single-port VRAM and the 32-entry palette memory between two requesters:
- the background/sprite render fetch engine;
- the CPU-side PPU register interface (PPUDATA reads/writes).

The renderer has strict priority. CPU writes are buffered in a small queue and drained only in idle bus cycles outside active rendering. CPU reads are serialised behind pending writes. The block sits between ppu_render / the register interface and the VRAM / palette_mem instances in the PPU top level.

---
 rtl/ppu_arb_pkg.sv | 36 +++
 rtl/ppu_arb_wq.sv | 69 ++++++
 rtl/ppu_vram_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_ppu_vram_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_arb_pkg.sv
`default_nettype none
//==============================================================================
// Module  : ppu_arb_pkg
// Brief   : Shared types, palette decode constant and mirror helper for the
//           PPU VRAM arbiter.
// Revision: 1.0
//==============================================================================
package ppu_arb_pkg;

    typedef enum logic [1:0] {
        C_IDLE    = 2'd0,
        C_RD_PEND = 2'd1,
        C_RD_DATA = 2'd2
    } cpu_state_t;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_REN    = 2'd1,
        OWN_CPU_WR = 2'd2,
        OWN_CPU_RD = 2'd3
    } bus_owner_t;

    localparam logic [5:0] PAL_BASE = 6'h3F;

    // Sprite backdrop entries 0x10/0x14/0x18/0x1C alias the background ones.
    function automatic logic [4:0] pal_mirror(input logic [4:0] addr);
        logic [4:0] mirrored;
        mirrored = addr;
        if (addr[4] && (addr[1:0] == 2'b00)) begin
            mirrored[4] = 1'b0;
        end
        return mirrored;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ppu_arb_wq.sv
`default_nettype none
//==============================================================================
// Module  : ppu_arb_wq
// Brief   : Synchronous FIFO holding buffered CPU writes {addr, data}.
// Revision: 1.0
//==============================================================================
module ppu_arb_wq #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 22
) (
    input  logic                     VGA_CLK,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int              AW        = $clog2(DEPTH);
    localparam logic [AW:0]     C_FULL    = (AW + 1)'(DEPTH);
    localparam logic [AW:0]     C_LVL_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0]   C_PTR_ONE = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_level == C_FULL);
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign head_data = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge VGA_CLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers are AW bits wide, so increments wrap modulo DEPTH on their own.
    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + C_LVL_ONE;
                2'b01:   r_level <= r_level - C_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ppu_vram_arbiter.sv
`default_nettype none
//==============================================================================
// Module  : ppu_vram_arbiter
// Brief   : Renderer-priority VRAM/palette arbiter with buffered CPU writes.
//           Optional starvation guard: PPU_ARB_STARVE_GUARD_EN.
// Revision: 1.0
//==============================================================================
module ppu_vram_arbiter
    import ppu_arb_pkg::*;
#(
    parameter int WQ_DEPTH     = 4,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                        VGA_CLK,
    input  logic                        reset,
    input  logic                        render_active,
    input  logic                        ren_req,
    input  logic [13:0]                 ren_addr,
    output logic                        ren_gnt,
    output logic                        ren_rvalid,
    output logic [7:0]                  ren_rdata,
    input  logic                        cpu_req,
    input  logic                        cpu_we,
    input  logic [13:0]                 cpu_addr,
    input  logic [7:0]                  cpu_wdata,
    output logic                        cpu_ready,
    output logic                        cpu_rvalid,
    output logic [7:0]                  cpu_rdata,
    output logic [15:0]                 vram_addr,
    output logic                        vram_we,
    output logic [7:0]                  vram_wdata,
    input  logic [7:0]                  vram_rdata,
    output logic [4:0]                  pal_addr,
    output logic                        pal_we,
    output logic [7:0]                  pal_wdata,
    input  logic [7:0]                  pal_rdata,
    output logic [$clog2(WQ_DEPTH):0]   wq_level
);

    localparam int LVL_W = $clog2(WQ_DEPTH) + 1;

    cpu_state_t     r_state;
    cpu_state_t     w_state_nxt;
    bus_owner_t     w_owner;
    logic [13:0]    r_rd_addr;
    logic           w_rd_latch;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic [21:0]    w_head;
    logic [LVL_W-1:0] w_level;
    logic           w_force;
    logic [13:0]    w_addr;
    logic           w_we;
    logic [7:0]     w_wdata;
    logic           w_sel_pal;
    logic           r_rd_pal;
    logic           r_ren_rvalid;
    logic [7:0]     r_cpu_rdata;
    logic [7:0]     w_rd_mux;

    ppu_arb_wq #(
        .DEPTH (WQ_DEPTH),
        .WIDTH (22)
    ) u_wq (
        .VGA_CLK   (VGA_CLK),
        .reset     (reset),
        .push      (w_push),
        .push_data ({cpu_addr, cpu_wdata}),
        .pop       (w_pop),
        .head_data (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .level     (w_level)
    );

    assign wq_level = w_level;

`ifdef PPU_ARB_STARVE_GUARD_EN
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    logic [WAIT_W-1:0] r_wait;
    logic              w_cpu_pending;
    logic              w_cpu_served;

    assign w_cpu_pending = !w_empty || (r_state == C_RD_PEND);
    assign w_cpu_served  = (w_owner == OWN_CPU_WR) || (w_owner == OWN_CPU_RD);
    assign w_force       = w_cpu_pending && (r_wait == WAIT_W'(STARVE_LIMIT));

    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            r_wait <= '0;
        end else if (w_cpu_served) begin
            r_wait <= '0;
        end else if (w_cpu_pending && (r_wait != WAIT_W'(STARVE_LIMIT))) begin
            r_wait <= r_wait + WAIT_W'(1);
        end
    end
`else
    logic w_unused_starve_limit;

    assign w_force               = 1'b0;
    assign w_unused_starve_limit = (STARVE_LIMIT != 0);
`endif

    // A pending read only reaches the bus once the write queue is empty,
    // which keeps CPU write-then-read ordering intact.
    always_comb begin
        w_owner = OWN_NONE;
        if (w_force) begin
            w_owner = !w_empty ? OWN_CPU_WR : OWN_CPU_RD;
        end else if (ren_req) begin
            w_owner = OWN_REN;
        end else if (!render_active && !w_empty) begin
            w_owner = OWN_CPU_WR;
        end else if (!render_active && (r_state == C_RD_PEND)) begin
            w_owner = OWN_CPU_RD;
        end
    end

    always_comb begin
        w_addr  = '0;
        w_we    = 1'b0;
        w_wdata = '0;
        case (w_owner)
            OWN_REN: begin
                w_addr = ren_addr;
            end
            OWN_CPU_WR: begin
                w_addr  = w_head[21:8];
                w_we    = 1'b1;
                w_wdata = w_head[7:0];
            end
            OWN_CPU_RD: begin
                w_addr = r_rd_addr;
            end
            default: begin
                w_addr = '0;
            end
        endcase
    end

    assign w_sel_pal  = (w_addr[13:8] == PAL_BASE);
    assign w_pop      = (w_owner == OWN_CPU_WR);
    assign ren_gnt    = (w_owner == OWN_REN);

    assign vram_addr  = {2'b00, w_addr};
    assign vram_we    = w_we && !w_sel_pal;
    assign vram_wdata = w_sel_pal ? 8'h00 : w_wdata;
    assign pal_addr   = pal_mirror(w_addr[4:0]);
    assign pal_we     = w_we && w_sel_pal;
    assign pal_wdata  = w_sel_pal ? w_wdata : 8'h00;

    always_comb begin
        w_state_nxt = r_state;
        cpu_ready   = 1'b0;
        w_push      = 1'b0;
        w_rd_latch  = 1'b0;
        case (r_state)
            C_IDLE: begin
                cpu_ready = !w_full;
                if (cpu_req && !w_full) begin
                    if (cpu_we) begin
                        w_push = 1'b1;
                    end else begin
                        w_rd_latch  = 1'b1;
                        w_state_nxt = C_RD_PEND;
                    end
                end
            end
            C_RD_PEND: begin
                if (w_owner == OWN_CPU_RD) begin
                    w_state_nxt = C_RD_DATA;
                end
            end
            C_RD_DATA: begin
                w_state_nxt = C_IDLE;
            end
            default: begin
                w_state_nxt = C_IDLE;
            end
        endcase
    end

    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            r_state      <= C_IDLE;
            r_rd_addr    <= '0;
            r_rd_pal     <= 1'b0;
            r_ren_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rd_pal     <= w_sel_pal;
            r_ren_rvalid <= ren_gnt;
            if (w_rd_latch) begin
                r_rd_addr <= cpu_addr;
            end
            if (r_state == C_RD_DATA) begin
                r_cpu_rdata <= w_rd_mux;
            end
        end
    end

    // The tag registered with each access picks which memory answers next cycle.
    assign w_rd_mux   = r_rd_pal ? pal_rdata : vram_rdata;
    assign ren_rvalid = r_ren_rvalid;
    assign ren_rdata  = r_ren_rvalid ? w_rd_mux : 8'h00;
    assign cpu_rvalid = (r_state == C_RD_DATA);
    assign cpu_rdata  = cpu_rvalid ? w_rd_mux : r_cpu_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ppu_vram_arbiter.sv
`default_nettype none
//==============================================================================
// Module  : tb_ppu_vram_arbiter
// Brief   : Directed self-checking bench for ppu_vram_arbiter.
// Revision: 1.0
//==============================================================================
module tb_ppu_vram_arbiter;

    localparam int WQ_DEPTH     = 4;
    localparam int STARVE_LIMIT = 8;
`ifdef PPU_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        VGA_CLK;
    logic        reset;
    logic        render_active;
    logic        ren_req;
    logic [13:0] ren_addr;
    logic        ren_gnt;
    logic        ren_rvalid;
    logic [7:0]  ren_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ready;
    logic        cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic [15:0] vram_addr;
    logic        vram_we;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata;
    logic [4:0]  pal_addr;
    logic        pal_we;
    logic [7:0]  pal_wdata;
    logic [7:0]  pal_rdata;
    logic [2:0]  wq_level;

    logic [7:0]  vmem [0:16383];
    logic [7:0]  pmem [0:31];

    int n_tests = 0;
    int n_fail  = 0;

    ppu_vram_arbiter #(
        .WQ_DEPTH     (WQ_DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .VGA_CLK       (VGA_CLK),
        .reset         (reset),
        .render_active (render_active),
        .ren_req       (ren_req),
        .ren_addr      (ren_addr),
        .ren_gnt       (ren_gnt),
        .ren_rvalid    (ren_rvalid),
        .ren_rdata     (ren_rdata),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_ready     (cpu_ready),
        .cpu_rvalid    (cpu_rvalid),
        .cpu_rdata     (cpu_rdata),
        .vram_addr     (vram_addr),
        .vram_we       (vram_we),
        .vram_wdata    (vram_wdata),
        .vram_rdata    (vram_rdata),
        .pal_addr      (pal_addr),
        .pal_we        (pal_we),
        .pal_wdata     (pal_wdata),
        .pal_rdata     (pal_rdata),
        .wq_level      (wq_level)
    );

    initial VGA_CLK = 1'b0;
    always #5 VGA_CLK = ~VGA_CLK;

    // Synchronous memories with one cycle of read latency.
    always @(posedge VGA_CLK) begin
        if (vram_we) vmem[vram_addr[13:0]] <= vram_wdata;
        vram_rdata <= vmem[vram_addr[13:0]];
        if (pal_we) pmem[pal_addr] <= pal_wdata;
        pal_rdata <= pmem[pal_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge VGA_CLK);
        #1;
    endtask

    task automatic cpu_write(input logic [13:0] a, input logic [7:0] d);
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
    endtask

    task automatic cpu_read(input logic [13:0] a);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = a;
    endtask

    initial begin
        int first_wr;
        int gnt_cnt;
        int cnt_rv;
        int cnt_we;
        logic [15:0] wr_addr;
        logic [7:0]  wr_data;
        logic        gnt_at_wr;
        logic [15:0] exp_addr [5];
        logic [2:0]  exp_lvl  [5];

        reset = 1'b1; render_active = 1'b0; ren_req = 1'b0; ren_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (2) @(posedge VGA_CLK);
        #1 reset = 1'b0;
        #2;
        check("rst_cpu_ready", cpu_ready, 1);
        check("rst_wq_level", wq_level, 0);
        check("rst_cpu_rvalid", cpu_rvalid, 0);
        check("rst_ren_gnt", ren_gnt, 0);
        check("rst_vram_we", vram_we, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);

        // Write then read back through VRAM.
        step(); cpu_write(14'h2000, 8'h55); #2;
        check("t1_wr_ready", cpu_ready, 1);
        step(); cpu_read(14'h2000); #2;
        check("t1_level", wq_level, 1);
        check("t1_vram_we", vram_we, 1);
        check("t1_vram_waddr", vram_addr, 16'h2000);
        check("t1_vram_wdata", vram_wdata, 8'h55);
        check("t1_rd_ready", cpu_ready, 1);
        step(); cpu_req = 1'b0; #2;
        check("t1_pend_ready", cpu_ready, 0);
        check("t1_vram_raddr", vram_addr, 16'h2000);
        check("t1_rd_no_we", vram_we, 0);
        step(); #2;
        check("t1_rvalid", cpu_rvalid, 1);
        check("t1_rdata", cpu_rdata, 8'h55);
        step(); #2;
        check("t1_rvalid_drop", cpu_rvalid, 0);
        check("t1_rdata_hold", cpu_rdata, 8'h55);

        // Renderer holds the bus for 10 cycles while a CPU write waits.
        first_wr = -1; gnt_cnt = 0; wr_addr = '0; wr_data = '0;
        for (int c = 0; c < 14; c++) begin
            step();
            ren_req  = (c < 10);
            ren_addr = 14'h2000;
            if (c == 0) cpu_write(14'h23C0, 8'hAA);
            else        cpu_req = 1'b0;
            #2;
            if (ren_gnt) gnt_cnt++;
            if (vram_we && first_wr < 0) begin
                first_wr = c; wr_addr = vram_addr; wr_data = vram_wdata;
            end
            if (c == 1) begin
                check("t2_ren_rvalid", ren_rvalid, 1);
                check("t2_ren_rdata", ren_rdata, 8'h55);
            end
        end
        check("t2_gnt_cycles", gnt_cnt, GUARD ? 9 : 10);
        check("t2_wr_cycle", first_wr, GUARD ? 9 : 10);
        check("t2_wr_addr", wr_addr, 16'h23C0);
        check("t2_wr_data", wr_data, 8'hAA);

        // Palette write to a mirrored entry, read back via its alias.
        step(); cpu_write(14'h3F10, 8'h0F); #2;
        step(); cpu_read(14'h3F00); #2;
        check("t3_pal_we", pal_we, 1);
        check("t3_wr_pal_addr", pal_addr, 0);
        check("t3_pal_wdata", pal_wdata, 8'h0F);
        check("t3_no_vram_we", vram_we, 0);
        step(); cpu_req = 1'b0; #2;
        check("t3_rd_pal_addr", pal_addr, 0);
        check("t3_rd_pal_we", pal_we, 0);
        step(); #2;
        check("t3_rvalid", cpu_rvalid, 1);
        check("t3_rdata", cpu_rdata, 8'h0F);

        // Fill the queue during rendering, then drain it.
        for (int i = 0; i < 5; i++) begin
            step();
            render_active = 1'b1;
            cpu_write(14'h0400 + 14'(i), 8'h10 + 8'(i));
            #2;
            check($sformatf("t4_fill_ready%0d", i), cpu_ready, (i < 4) ? 1 : 0);
            check($sformatf("t4_fill_no_we%0d", i), vram_we, 0);
        end
        check("t4_full_level", wq_level, 4);
        exp_addr = '{16'h0400, 16'h0401, 16'h0402, 16'h0403, 16'h0404};
        exp_lvl  = '{3'd4, 3'd3, 3'd3, 3'd2, 3'd1};
        for (int c = 0; c < 5; c++) begin
            step();
            render_active = 1'b0;
            if (c >= 2) cpu_req = 1'b0;
            #2;
            if (c == 0) check("t4_ready_full", cpu_ready, 0);
            if (c == 1) check("t4_ready_free", cpu_ready, 1);
            check($sformatf("t4_drain_we%0d", c), vram_we, 1);
            check($sformatf("t4_drain_addr%0d", c), vram_addr, exp_addr[c]);
            check($sformatf("t4_drain_data%0d", c), vram_wdata, 8'h10 + 8'(c));
            check($sformatf("t4_drain_level%0d", c), wq_level, exp_lvl[c]);
        end
        step(); #2;
        check("t4_empty_level", wq_level, 0);
        check("t4_empty_we", vram_we, 0);

        // Reset while a read is pending behind two queued writes.
        step(); render_active = 1'b1; cpu_write(14'h0100, 8'h01); #2;
        step(); cpu_write(14'h0101, 8'h02); #2;
        step(); cpu_read(14'h0100); #2;
        check("t5_rd_ready", cpu_ready, 1);
        step(); cpu_req = 1'b0; #2;
        check("t5_pend_ready", cpu_ready, 0);
        check("t5_pend_level", wq_level, 2);
        reset = 1'b1; #2;
        check("t5_async_level", wq_level, 0);
        step(); step();
        reset = 1'b0; render_active = 1'b0; #2;
        check("t5_level", wq_level, 0);
        check("t5_ready", cpu_ready, 1);
        cnt_rv = 0; cnt_we = 0;
        for (int c = 0; c < 6; c++) begin
            step(); #2;
            if (cpu_rvalid) cnt_rv++;
            if (vram_we) cnt_we++;
        end
        check("t5_no_rvalid", cnt_rv, 0);
        check("t5_no_vram_we", cnt_we, 0);

        // Renderer never releases the bus with one write queued.
        step(); ren_req = 1'b1; ren_addr = 14'h0000; cpu_write(14'h0555, 8'h66); #2;
        first_wr = -1; gnt_at_wr = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step(); cpu_req = 1'b0; #2;
            if (vram_we && first_wr < 0) begin
                first_wr = c; gnt_at_wr = ren_gnt;
            end
        end
        check("t6_wr_cycle", first_wr, GUARD ? 9 : -1);
        check("t6_gnt_at_wr", gnt_at_wr, GUARD ? 0 : 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
